sqrt2_host: RTL and testbench

Initiator side of the sqrt2 shared-bus protocol. Accepts FP16 operands on a valid/ready stream and drives ENABLE plus the bidirectional IO_DATA bus to a sqrt2 unit. Releases the bus, waits for RESULT, captures the root and the IS_NAN/IS_PINF/IS_NINF flags, then returns them on an output valid/ready stream. Sits between the system datapath and one sqrt2 instance, and owns bus direction and ENABLE sequencing.

---
 rtl/sqrt2_pkg.sv | 36 +++
 rtl/sqrt2_bus_pad.sv | 44 ++++
 rtl/sqrt2_host.sv | 215 +++++++++++++++++++++
 tb/tb_sqrt2_host.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt2_pkg.sv
// ----------------------------------------------------------------------------
// sqrt2_pkg
// Shared definitions for the sqrt2 host slice.
//   - FP16_W     : width of an FP16 word on every data path
//   - FP16_QNAN  : quiet NaN returned when a transaction is aborted
//   - FP16_PINF  : positive infinity encoding
//   - state_t    : host FSM states
//   - cnt_width  : bit width needed for a counter that holds 0..max_count-1
// ----------------------------------------------------------------------------
package sqrt2_pkg;

  localparam int FP16_W = 16;

  localparam logic [FP16_W-1:0] FP16_QNAN = 16'hfe00;
  localparam logic [FP16_W-1:0] FP16_PINF = 16'h7c00;

  // IDLE  : waiting for an operand
  // DRIVE : operand on the shared bus, ENABLE high
  // WAIT  : bus released, waiting for RESULT or the timeout
  // HOLD  : result presented on the output stream
  // GAP   : ENABLE kept low before the next operand is accepted
  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    HOLD,
    GAP
  } state_t;

  // A counter that only ever holds 0..max_count-1 needs clog2(max_count)
  // bits, but never fewer than one.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/sqrt2_bus_pad.sv
// ----------------------------------------------------------------------------
// sqrt2_bus_pad
// Tristate driver for the shared IO_DATA bus. Both the output enable and the
// driven value are registered, so the bus only changes direction on a clock
// edge and never glitches while the FSM decodes its next state.
//
// Ports:
//   clk         clock, all logic on posedge
//   rst_n       synchronous active-low reset; releases the bus
//   drive_next  host wants to drive the bus during the next cycle
//   drive_data  value to drive during the next cycle
//   bus         shared bidirectional bus to the sqrt2 unit
//   bus_in      current bus value, sampled by the host FSM on its clock
// ----------------------------------------------------------------------------
module sqrt2_bus_pad
  import sqrt2_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              drive_next,
  input  logic [FP16_W-1:0] drive_data,
  inout  wire  [FP16_W-1:0] bus,
  output logic [FP16_W-1:0] bus_in
);

  logic              oe;
  logic [FP16_W-1:0] data;

  // Output enable and data are loaded together so the bus is either released
  // or carries a stable, fully settled value for the whole cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oe   <= 1'b0;
      data <= '0;
    end else begin
      oe   <= drive_next;
      data <= drive_data;
    end
  end

  assign bus    = oe ? data : {FP16_W{1'bz}};
  assign bus_in = bus;

endmodule

// File: rtl/sqrt2_host.sv
// ----------------------------------------------------------------------------
// sqrt2_host
// Initiator for the sqrt2 shared-bus protocol. Takes one FP16 operand from a
// valid/ready stream, raises ENABLE and drives the operand on IO_DATA for
// DRIVE_CYCLES clocks, releases the bus and waits for RESULT (or TIMEOUT
// clocks), captures the root and flags, and returns them on a valid/ready
// output stream. ENABLE is held low for at least GAP_CYCLES clocks between
// transactions.
//
// Ports:
//   CLK, RST_N                   clock, synchronous active-low reset
//   IN_VALID/IN_READY/IN_DATA    operand stream (accepted only in IDLE)
//   OUT_VALID/OUT_READY/OUT_DATA result stream
//   OUT_NAN/OUT_PINF/OUT_NINF    flags captured from the sqrt2 unit
//   OUT_TIMEOUT                  transaction aborted, OUT_DATA is quiet NaN
//   ENABLE                       to sqrt2 ENABLE
//   IO_DATA                      shared bus, driven only in DRIVE
//   IS_NAN/IS_PINF/IS_NINF       flags from the sqrt2 unit
//   RESULT                       sqrt2 result strobe
// ----------------------------------------------------------------------------
module sqrt2_host
  import sqrt2_pkg::*;
#(
  parameter int DRIVE_CYCLES = 2,
  parameter int TIMEOUT      = 31,
  parameter int GAP_CYCLES   = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [FP16_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [FP16_W-1:0] OUT_DATA,
  output logic              OUT_NAN,
  output logic              OUT_PINF,
  output logic              OUT_NINF,
  output logic              OUT_TIMEOUT,
  output logic              ENABLE,
  inout  wire  [FP16_W-1:0] IO_DATA,
  input  logic              IS_NAN,
  input  logic              IS_PINF,
  input  logic              IS_NINF,
  input  logic              RESULT
);

  localparam int PHASE_MAX = (TIMEOUT > DRIVE_CYCLES) ? TIMEOUT : DRIVE_CYCLES;
  localparam int PHASE_W   = cnt_width(PHASE_MAX);
  localparam int GAP_W     = cnt_width(GAP_CYCLES + 1);

  localparam logic [PHASE_W-1:0] DRIVE_LAST   = PHASE_W'(DRIVE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] TIMEOUT_LAST = PHASE_W'(TIMEOUT - 1);
  localparam logic [PHASE_W-1:0] PHASE_ONE    = PHASE_W'(1);
  localparam logic [GAP_W-1:0]   GAP_DONE     = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0]   GAP_ONE      = GAP_W'(1);

  state_t             state;
  state_t             state_next;
  logic [PHASE_W-1:0] phase_cnt;
  logic [PHASE_W-1:0] phase_cnt_next;
  logic [GAP_W-1:0]   gap_cnt;
  logic [GAP_W-1:0]   gap_cnt_next;

  logic              load_operand;
  logic              capture_result;
  logic              capture_timeout;
  logic              out_accept;
  logic              drive_next;
  logic [FP16_W-1:0] operand;
  logic [FP16_W-1:0] drive_value;
  logic [FP16_W-1:0] bus_value;

  // The pad registers its data, so on the accepting edge it must see the new
  // operand straight from the input rather than the stale operand register.
  assign drive_value = load_operand ? IN_DATA : operand;
  assign drive_next  = (state_next == DRIVE);

  sqrt2_bus_pad u_pad (
    .clk        (CLK),
    .rst_n      (RST_N),
    .drive_next (drive_next),
    .drive_data (drive_value),
    .bus        (IO_DATA),
    .bus_in     (bus_value)
  );

  // State and counter registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      phase_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_next;
      phase_cnt <= phase_cnt_next;
      gap_cnt   <= gap_cnt_next;
    end
  end

  // Next-state logic. phase_cnt times both DRIVE and WAIT; gap_cnt counts the
  // clocks ENABLE has been low, starting on HOLD entry, and saturates so a
  // slow consumer lets the host skip GAP entirely.
  always_comb begin
    state_next      = state;
    phase_cnt_next  = phase_cnt;
    gap_cnt_next    = gap_cnt;
    load_operand    = 1'b0;
    capture_result  = 1'b0;
    capture_timeout = 1'b0;
    out_accept      = 1'b0;

    case (state)
      IDLE: begin
        if (IN_VALID && IN_READY) begin
          load_operand   = 1'b1;
          phase_cnt_next = '0;
          state_next     = DRIVE;
        end
      end

      DRIVE: begin
        if (phase_cnt == DRIVE_LAST) begin
          phase_cnt_next = '0;
          state_next     = WAIT;
        end else begin
          phase_cnt_next = phase_cnt + PHASE_ONE;
        end
      end

      // RESULT is tested first so it wins over an expiring timeout.
      WAIT: begin
        if (RESULT) begin
          capture_result = 1'b1;
          gap_cnt_next   = '0;
          state_next     = HOLD;
        end else if (phase_cnt == TIMEOUT_LAST) begin
          capture_timeout = 1'b1;
          gap_cnt_next    = '0;
          state_next      = HOLD;
        end else begin
          phase_cnt_next = phase_cnt + PHASE_ONE;
        end
      end

      HOLD: begin
        if (gap_cnt != GAP_DONE) begin
          gap_cnt_next = gap_cnt + GAP_ONE;
        end
        if (OUT_VALID && OUT_READY) begin
          out_accept = 1'b1;
          state_next = (gap_cnt_next == GAP_DONE) ? IDLE : GAP;
        end
      end

      GAP: begin
        if (gap_cnt != GAP_DONE) begin
          gap_cnt_next = gap_cnt + GAP_ONE;
        end
        if (gap_cnt_next == GAP_DONE) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered handshake and ENABLE outputs follow the next state, so they
  // line up exactly with the state the FSM is in during each cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      IN_READY <= 1'b0;
      ENABLE   <= 1'b0;
      operand  <= '0;
    end else begin
      IN_READY <= (state_next == IDLE);
      ENABLE   <= (state_next == DRIVE) || (state_next == WAIT);
      if (load_operand) begin
        operand <= IN_DATA;
      end
    end
  end

  // Result registers: loaded on capture or abort, held until accepted.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      OUT_VALID   <= 1'b0;
      OUT_DATA    <= '0;
      OUT_NAN     <= 1'b0;
      OUT_PINF    <= 1'b0;
      OUT_NINF    <= 1'b0;
      OUT_TIMEOUT <= 1'b0;
    end else if (capture_result) begin
      OUT_VALID   <= 1'b1;
      OUT_DATA    <= bus_value;
      OUT_NAN     <= IS_NAN;
      OUT_PINF    <= IS_PINF;
      OUT_NINF    <= IS_NINF;
      OUT_TIMEOUT <= 1'b0;
    end else if (capture_timeout) begin
      OUT_VALID   <= 1'b1;
      OUT_DATA    <= FP16_QNAN;
      OUT_NAN     <= 1'b0;
      OUT_PINF    <= 1'b0;
      OUT_NINF    <= 1'b0;
      OUT_TIMEOUT <= 1'b1;
    end else if (out_accept) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sqrt2_host.sv
// ----------------------------------------------------------------------------
// tb_sqrt2_host
// Self-checking bench for sqrt2_host. A behavioural sqrt2 responder answers
// on the shared bus with a programmable latency; a scoreboard holds the
// expected root/flags for each operand computed from FP16 arithmetic.
// ----------------------------------------------------------------------------
module tb_sqrt2_host;

  localparam int DRIVE_CYCLES = 2;
  localparam int TIMEOUT      = 31;
  localparam int GAP_CYCLES   = 1;

  logic        CLK       = 1'b0;
  logic        RST_N     = 1'b0;
  logic        IN_VALID  = 1'b0;
  logic [15:0] IN_DATA   = 16'h0;
  logic        OUT_READY = 1'b1;
  logic        IS_NAN    = 1'b0;
  logic        IS_PINF   = 1'b0;
  logic        IS_NINF   = 1'b0;
  logic        RESULT    = 1'b0;
  logic        IN_READY;
  logic        OUT_VALID;
  logic [15:0] OUT_DATA;
  logic        OUT_NAN;
  logic        OUT_PINF;
  logic        OUT_NINF;
  logic        OUT_TIMEOUT;
  logic        ENABLE;
  wire  [15:0] IO_DATA;

  logic        resp_oe  = 1'b0;
  logic        park_oe  = 1'b0;
  logic [15:0] resp_val = 16'h0;

  assign IO_DATA = resp_oe ? resp_val : (park_oe ? 16'h5a5a : 16'hzzzz);

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] op;
    int          lat;
  } job_t;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  flags;
  } exp_t;

  job_t job_q[$];
  exp_t exp_q[$];

  sqrt2_host #(
    .DRIVE_CYCLES (DRIVE_CYCLES),
    .TIMEOUT      (TIMEOUT),
    .GAP_CYCLES   (GAP_CYCLES)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .IN_DATA     (IN_DATA),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .OUT_DATA    (OUT_DATA),
    .OUT_NAN     (OUT_NAN),
    .OUT_PINF    (OUT_PINF),
    .OUT_NINF    (OUT_NINF),
    .OUT_TIMEOUT (OUT_TIMEOUT),
    .ENABLE      (ENABLE),
    .IO_DATA     (IO_DATA),
    .IS_NAN      (IS_NAN),
    .IS_PINF     (IS_PINF),
    .IS_NINF     (IS_NINF),
    .RESULT      (RESULT)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic longint unsigned isqrt(input longint unsigned n);
    longint unsigned r = 0;
    longint unsigned b;
    for (int i = 27; i >= 0; i--) begin
      b = r | (64'd1 << i);
      if (b * b <= n) r = b;
    end
    return r;
  endfunction

  // FP16 square root with a truncated mantissa: {nan, pinf, ninf, root}.
  function automatic logic [18:0] sqrtRef(input logic [15:0] x);
    logic [4:0]      ex;
    logic [9:0]      mf;
    int              m;
    int              e;
    int              sh;
    int              p;
    int              er;
    longint unsigned n;
    longint unsigned r;
    longint unsigned r11;
    logic [4:0]      be;
    logic [9:0]      m10;
    ex = x[14:10];
    mf = x[9:0];
    if (ex == 5'h1f && mf != 10'h0) return {3'b100, 16'hfe00};
    if (x == 16'h7c00) return {3'b010, 16'h7c00};
    if (x == 16'hfc00) return {3'b101, 16'hfe00};
    if (x[14:0] == 15'h0) return {3'b000, x};
    if (x[15]) return {3'b100, 16'hfe00};
    if (ex == 5'h0) begin
      m = int'(mf);
      e = -24;
    end else begin
      m = 1024 + int'(mf);
      e = int'(ex) - 25;
    end
    sh  = 40 + ((e - 40) & 1);
    n   = longint'(m) << sh;
    r   = isqrt(n);
    p   = 0;
    for (int i = 0; i < 40; i++) if (r[i]) p = i;
    r11 = r >> (p - 10);
    er  = (e - sh) / 2 + (p - 10);
    be  = 5'(er + 25);
    m10 = 10'(r11);
    return {3'b000, 1'b0, be, m10};
  endfunction

  // Behavioural sqrt2 unit: reads the operand while the host drives it, then
  // drives the root on the bus and raises RESULT after cur.lat WAIT clocks.
  job_t        cur;
  int          en_cnt  = 0;
  int          low_cnt = 99;
  logic [18:0] resp_ref;
  int          exp_len;

  always @(negedge CLK) begin
    if (!RST_N) begin
      en_cnt  = 0;
      low_cnt = 99;
      resp_oe = 1'b0;
      RESULT  = 1'b0;
      IS_NAN  = 1'b0;
      IS_PINF = 1'b0;
      IS_NINF = 1'b0;
    end else if (ENABLE) begin
      en_cnt++;
      checkOutput("in_ready_busy", 32'(IN_READY), 32'd0);
      if (en_cnt == 1) begin
        checkOutput("enable_gap", 32'(low_cnt >= GAP_CYCLES), 32'd1);
        checkOutput("job_pending", 32'(job_q.size() > 0), 32'd1);
        if (job_q.size() > 0) cur = job_q.pop_front();
        low_cnt = 0;
      end
      if (en_cnt <= DRIVE_CYCLES) begin
        checkOutput("drive_bus", 32'(IO_DATA), 32'(cur.op));
      end else begin
        if (resp_oe) checkOutput("bus_release", 32'(IO_DATA), 32'(resp_val));
        resp_ref = sqrtRef(cur.op);
        resp_val = resp_ref[15:0];
        resp_oe  = 1'b1;
        if (cur.lat != 0 && en_cnt == DRIVE_CYCLES + cur.lat) begin
          RESULT  = 1'b1;
          IS_NAN  = resp_ref[18];
          IS_PINF = resp_ref[17];
          IS_NINF = resp_ref[16];
        end
      end
    end else begin
      if (en_cnt > 0) begin
        exp_len = DRIVE_CYCLES + ((cur.lat == 0 || cur.lat > TIMEOUT) ? TIMEOUT : cur.lat);
        checkOutput("enable_len", 32'(en_cnt), 32'(exp_len));
      end
      en_cnt  = 0;
      low_cnt++;
      resp_oe = 1'b0;
      RESULT  = 1'b0;
      IS_NAN  = 1'b0;
      IS_PINF = 1'b0;
      IS_NINF = 1'b0;
    end
  end

  // Output monitor: scoreboard compare on each handshake, stability while
  // the consumer stalls.
  logic        hold_prev = 1'b0;
  logic [19:0] prev_out;
  exp_t        e_head;

  always @(negedge CLK) begin
    if (!RST_N) begin
      hold_prev = 1'b0;
    end else begin
      if (OUT_VALID) begin
        checkOutput("enable_in_hold", 32'(ENABLE), 32'd0);
        checkOutput("in_ready_hold", 32'(IN_READY), 32'd0);
        if (hold_prev)
          checkOutput("hold_stable", 32'({OUT_DATA, OUT_TIMEOUT, OUT_NAN, OUT_PINF, OUT_NINF}),
                      32'(prev_out));
      end
      if (OUT_VALID && OUT_READY) begin
        checkOutput("exp_pending", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
          e_head = exp_q.pop_front();
          checkOutput("out_data", 32'(OUT_DATA), 32'(e_head.data));
          checkOutput("out_flags", 32'({OUT_TIMEOUT, OUT_NAN, OUT_PINF, OUT_NINF}),
                      32'(e_head.flags));
        end
        hold_prev = 1'b0;
      end else if (OUT_VALID) begin
        hold_prev = 1'b1;
        prev_out  = {OUT_DATA, OUT_TIMEOUT, OUT_NAN, OUT_PINF, OUT_NINF};
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  // Offers one operand; lat is the responder's RESULT delay in WAIT clocks
  // (0 = never answers). Returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [15:0] op, input int lat, input bit hold_valid);
    int          n = 0;
    logic [18:0] r;
    exp_t        ex;
    while (!IN_READY && n < 400) begin
      @(posedge CLK);
      #1;
      n++;
    end
    checkOutput("in_ready_wait", 32'(IN_READY), 32'd1);
    r = sqrtRef(op);
    if (lat == 0 || lat > TIMEOUT) begin
      ex.data  = 16'hfe00;
      ex.flags = 4'b1000;
    end else begin
      ex.data  = r[15:0];
      ex.flags = {1'b0, r[18:16]};
    end
    job_q.push_back('{op: op, lat: lat});
    exp_q.push_back(ex);
    IN_VALID = 1'b1;
    IN_DATA  = op;
    @(posedge CLK);
    #1;
    if (!hold_valid) IN_VALID = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(posedge CLK);
      #1;
      n++;
    end
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic waitOutValid();
    int n = 0;
    while (!OUT_VALID && n < 400) begin
      @(posedge CLK);
      #1;
      n++;
    end
    checkOutput("out_valid_wait", 32'(OUT_VALID), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [15:0] rop;

  initial begin
    $display("[TB] sqrt2_host bench start");
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_enable", 32'(ENABLE), 32'd0);
    checkOutput("rst_out_valid", 32'(OUT_VALID), 32'd0);
    checkOutput("rst_in_ready", 32'(IN_READY), 32'd0);
    checkOutput("rst_out_data", 32'(OUT_DATA), 32'd0);
    checkOutput("rst_flags", 32'({OUT_TIMEOUT, OUT_NAN, OUT_PINF, OUT_NINF}), 32'd0);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("ready_after_reset", 32'(IN_READY), 32'd1);

    $display("[TB] basic transaction");
    applyStimulus(16'h1234, 3, 1'b0);
    checkOutput("enable_rise", 32'(ENABLE), 32'd1);
    waitDone();

    $display("[TB] back-to-back specials");
    applyStimulus(16'h7c00, 2, 1'b1);
    applyStimulus(16'hffff, 1, 1'b1);
    applyStimulus(16'h8000, 5, 1'b0);
    waitDone();

    $display("[TB] timeout");
    applyStimulus(16'h3c00, 0, 1'b0);
    waitDone();

    $display("[TB] output backpressure");
    OUT_READY = 1'b0;
    applyStimulus(16'h6066, 4, 1'b0);
    waitOutValid();
    repeat (5) begin
      @(posedge CLK);
      #1;
      checkOutput("bp_data", 32'(OUT_DATA), 32'h4dee);
      checkOutput("bp_valid", 32'(OUT_VALID), 32'd1);
      checkOutput("bp_in_ready", 32'(IN_READY), 32'd0);
    end
    OUT_READY = 1'b1;
    waitDone();

    $display("[TB] reset during drive");
    applyStimulus(16'h10c7, 3, 1'b0);
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    checkOutput("mid_rst_enable", 32'(ENABLE), 32'd0);
    checkOutput("mid_rst_out_valid", 32'(OUT_VALID), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(IN_READY), 32'd0);
    park_oe = 1'b1;
    #1;
    checkOutput("mid_rst_bus", 32'(IO_DATA), 32'h5a5a);
    park_oe = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    job_q.delete();
    exp_q.delete();
    applyStimulus(16'h0016, 2, 1'b0);
    waitDone();

    $display("[TB] result on timeout edge");
    applyStimulus(16'h002c, TIMEOUT, 1'b0);
    waitDone();

    $display("[TB] random operands");
    for (int i = 0; i < 16; i++) begin
      rop = 16'($urandom) & 16'h7fff;
      if (rop[14:10] == 5'h1f) rop[14:10] = 5'h1e;
      OUT_READY = 1'b0;
      applyStimulus(rop, int'($urandom_range(1, 8)), 1'b0);
      waitOutValid();
      repeat ($urandom_range(0, 3)) begin
        @(posedge CLK);
        #1;
      end
      OUT_READY = 1'b1;
      waitDone();
    end

    repeat (4) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
